// File: rtl/wishbone_master_adapter_if.sv
// rtl/wishbone_master_adapter_if.sv - core request/response and Wishbone initiator signal bundle
interface wishbone_master_adapter_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic [3:0]  req_sel_i;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic [31:0] wb_addr_o;
   logic [31:0] wb_data_o;
   logic [31:0] wb_data_i;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic        wb_ack_i;

   modport master (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_sel_i,
      input  wb_data_i, wb_ack_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
      output wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
   );

   modport slave (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_sel_i,
      output wb_data_i, wb_ack_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
      input  wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
   );
endinterface

// File: rtl/wishbone_master_adapter.sv
// rtl/wishbone_master_adapter.sv - one Wishbone classic cycle per core load/store, with ACK timeout
module wishbone_master_adapter #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   wishbone_master_adapter_if.master  bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_cyc;
   logic             r_we;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [3:0]       r_sel;
   logic             r_resp_valid;
   logic             r_resp_err;
   logic [31:0]      r_resp_rdata;

   logic w_accept;
   logic w_timeout;

   assign w_accept  = bus.req_valid_i && (r_state == S_IDLE);
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_cyc        <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_sel        <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         // Response flags are single-cycle pulses; only the BUSY exit raises them.
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_we    <= bus.req_we_i;
                  r_addr  <= bus.req_addr_i;
                  r_wdata <= bus.req_wdata_i;
                  r_sel   <= bus.req_sel_i;
                  r_cyc   <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (bus.wb_ack_i) begin
                  r_cyc        <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= r_we ? 32'h0 : bus.wb_data_i;
                  r_state      <= S_RESP;
               end else if (w_timeout) begin
                  r_cyc        <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= 1'b1;
                  r_resp_rdata <= 32'h0;
                  r_state      <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_cyc   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready_o  = (r_state == S_IDLE);
   assign bus.resp_valid_o = r_resp_valid;
   assign bus.resp_err_o   = r_resp_err;
   assign bus.resp_rdata_o = r_resp_rdata;
   assign bus.wb_cyc_o     = r_cyc;
   assign bus.wb_stb_o     = r_cyc;
   assign bus.wb_we_o      = r_we;
   assign bus.wb_addr_o    = r_addr;
   assign bus.wb_data_o    = r_wdata;
   assign bus.wb_sel_o     = r_sel;
endmodule
